// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: captures one ALU result word and shifts it out on a UART
// TX line. The frame is 8 data bits, LSB first, with the result zero-extended
// to 8 bits. Without parity the frame is 8N1.
// Optional feature: define ALU_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
// o_tx is a register that follows the frame state one cycle later. The line
// therefore falls on the edge after acceptance, and the stop bit's last
// cycle is also the single idle-high gap before a back-to-back frame.
module alu_result_uart_tx #(
  parameter int NB_DATA      = 6,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef ALU_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, tx_d;
  logic          tick, accept;
`ifdef ALU_TX_PARITY_EN
  logic          par_q;
`endif

  assign tick   = (cnt_q == CNT_LAST);
  assign accept = i_valid && o_ready;
  assign o_tx   = tx_q;

  // State register
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: every non-idle state lasts one bit period
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_START;
      S_START: if (tick) state_d = S_DATA;
`ifdef ALU_TX_PARITY_EN
      S_DATA:   if (tick && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
`else
      S_DATA:  if (tick && bit_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the line level for the current state, plus handshake and done
  always_comb begin
    tx_d    = 1'b1;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE:   o_ready = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef ALU_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      S_STOP: begin
        tx_d   = 1'b1;
        o_done = tick;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath: baud counter, bit index, shift register, and the registered line
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef ALU_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (state_q == S_IDLE || tick) cnt_q <= '0;
      else                           cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        // Snapshot the word so later i_data changes cannot disturb the frame
        shift_q <= 8'(i_data);
`ifdef ALU_TX_PARITY_EN
        par_q   <= ^i_data;
`endif
      end
      if (state_q == S_START && tick) bit_q <= 3'd0;
      if (state_q == S_DATA && tick) begin
        shift_q <= shift_q >> 1;
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx with CLKS_PER_BIT=4 and NB_DATA=6.
// Frame contents are hand-written per vector. Outputs are sampled on the falling edge.
module tb_alu_result_uart_tx;

  localparam int CPB = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [5:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  alu_result_uart_tx #(.NB_DATA(6), .CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_tx      (o_tx),
    .o_done    (o_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with the block idle. Sends d and checks the whole
  // frame cycle by cycle. The call returns at the falling edge after the edge
  // at which o_done was sampled.
  task automatic run_frame(input logic [5:0] d, input logic [7:0] exp_byte,
                           input logic exp_par, input bit hold, input bit inject);
    logic [10:0] fr;
    int done_k, n_done;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = exp_byte;
`ifdef ALU_TX_PARITY_EN
    fr[9] = exp_par;
`else
    if (exp_par === 1'bx) fr[9] = 1'b1;
`endif
    done_k = -1;
    n_done = 0;
    i_data = d;
    i_valid = 1'b1;
    chk("ready_idle", int'(o_ready), 1);
    @(posedge clock);
    @(negedge clock);
    if (!hold) i_valid = 1'b0;
    chk("tx_idle_k0", int'(o_tx), 1);
    chk("ready_drop", int'(o_ready), 0);
    for (int k = 1; k <= FB*CPB; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (inject && k == 10) begin i_valid = 1'b1; i_data = 6'h01; end
      if (inject && k == 14) i_valid = 1'b0;
      if (o_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) chk("start_edge", int'(o_tx), 0);
      if (k % CPB == 2) chk("frame_bit", int'(o_tx), int'(fr[k/CPB]));
      if (k < FB*CPB) chk("busy_ready", int'(o_ready), 0);
      else            chk("ready_back", int'(o_ready), 1);
    end
    chk("done_cycle", done_k, FB*CPB - 1);
    chk("done_count", n_done, 1);
  endtask

  initial begin
    int lows, dones;
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_done", int'(o_done), 0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single word: frame 0,1,0,1,1,0,1,0,0,1
    run_frame(6'b101101, 8'b00101101, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);

    // Zero extension: data bits 1,1,1,1,1,1,0,0
    run_frame(6'h3F, 8'b00111111, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);

    // A request made while busy is dropped. The line must stay idle afterwards.
    run_frame(6'h2A, 8'b00101010, 1'b1, 1'b0, 1'b1);
    lows = 0;
    repeat (12) begin
      @(negedge clock);
      if (!o_tx) lows++;
    end
    chk("no_queue", lows, 0);

    // Back-to-back frames with i_valid held high
    run_frame(6'h15, 8'b00010101, 1'b1, 1'b1, 1'b0);
    run_frame(6'h0A, 8'b00001010, 1'b0, 1'b1, 1'b0);
    i_valid = 1'b0;
    repeat (3) @(negedge clock);

    // Three ones: parity bit 1 when enabled
    run_frame(6'h07, 8'b00000111, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clock);

    // Reset during data bit 3 of 0x37; that bit is 0
    i_data = 6'h37;
    i_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_valid = 1'b0;
    repeat (18) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("pre_rst_bit3", int'(o_tx), 0);
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(o_tx), 1);
    chk("mid_rst_ready", int'(o_ready), 1);
    chk("mid_rst_done", int'(o_done), 0);
    @(negedge clock);
    i_reset_n = 1'b1;
    lows = 0;
    dones = 0;
    repeat (50) begin
      @(negedge clock);
      if (!o_tx) lows++;
      if (o_done) dones++;
    end
    chk("post_rst_tx_low", lows, 0);
    chk("post_rst_done", dones, 0);
    chk("post_rst_ready", int'(o_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
